// File: rtl/pixel_pkg.sv
// pixel_pkg: shared definitions for the pixel memory arbiter and the raster
// scan counter.
//   - default widths and frame geometry (640x240 screen, 2 pixels per address)
//   - arbiter FSM state encoding
//   - address field helpers: address = {row j, pair index i}
package pixel_pkg;

  localparam int PIX_N      = 32;
  localparam int PIX_HALF   = PIX_N / 2;
  localparam int PIX_I_MAX  = 320;
  localparam int PIX_J_MAX  = 240;
  localparam int PIX_STARVE = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DISP   = 2'd1,
    S_CPU_WR = 2'd2,
    S_CPU_RD = 2'd3
  } pix_state_e;

  // Row j lives in the upper half of the address.
  function automatic logic [PIX_HALF-1:0] pix_row(input logic [PIX_N-1:0] addr);
    return addr[PIX_N-1:PIX_HALF];
  endfunction

  // Pixel-pair index i lives in the lower half of the address.
  function automatic logic [PIX_HALF-1:0] pix_pair(input logic [PIX_N-1:0] addr);
    return addr[PIX_HALF-1:0];
  endfunction

  // True when both coordinates fall inside the visible frame.
  function automatic logic pix_in_range(input logic [PIX_N-1:0]    addr,
                                        input logic [PIX_HALF-1:0] i_max,
                                        input logic [PIX_HALF-1:0] j_max);
    return (pix_pair(addr) < i_max) && (pix_row(addr) < j_max);
  endfunction

endpackage

// File: rtl/pixel_mem_arbiter_if.sv
// pixel_mem_arbiter_if: CPU load/store handshake into the pixel region.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : driven by the CPU (master), held
//                                       stable until cpu_ack
//   cpu_ack/cpu_err/cpu_rdata         : returned by the arbiter (slave)
interface pixel_mem_arbiter_if #(
  parameter int N = 32
);
  logic         cpu_req;
  logic         cpu_we;
  logic [N-1:0] cpu_addr;
  logic [N-1:0] cpu_wdata;
  logic         cpu_ack;
  logic         cpu_err;
  logic [N-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_err, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_err, cpu_rdata
  );
endinterface

// File: rtl/pixel_scan_counter.sv
// pixel_scan_counter: x/y raster position counter.
//   clk, rst : clock, synchronous active-high reset to (0,0)
//   advance  : step to the next position (x first, then y)
//   restart  : return to (0,0); wins over advance
//   x, y     : current position; x wraps at X_MAX-1, y wraps at Y_MAX-1
module pixel_scan_counter #(
  parameter int X_MAX = 320,
  parameter int Y_MAX = 240,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         restart,
  output logic [W-1:0] x,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] X_LAST = W'(X_MAX - 1);
  localparam logic [W-1:0] Y_LAST = W'(Y_MAX - 1);

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;

  // Next raster position; restart takes effect regardless of advance.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (restart) begin
      x_d = {W{1'b0}};
      y_d = {W{1'b0}};
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_d = {W{1'b0}};
        if (y_q == Y_LAST) begin
          y_d = {W{1'b0}};
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= {W{1'b0}};
      y_q <= {W{1'b0}};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter: shares the single-port 2-bit pixel memory between the
// CPU load/store path and the display scan-out path.
//   clk, rst            : clock, synchronous active-high reset
//   cpu (slave modport) : CPU request/ack handshake, see pixel_mem_arbiter_if
//   disp_req            : display wants the next pixel pair (level)
//   disp_frame_start    : restart the scan at (0,0)
//   disp_valid/data/x/y : returned pixel pair and the coordinates it came from
//   mem_enable          : memory write enable (memory writes on negedge)
//   mem_address         : memory address {row, pair}
//   mem_data_in         : memory write data
//   mem_data_out        : memory read data, registered by the memory
// Display has priority; a CPU request that has lost STARVE-1 consecutive
// cycles is forced through on the next one.
module pixel_mem_arbiter
  import pixel_pkg::*;
#(
  parameter int N      = PIX_N,
  parameter int I_MAX  = PIX_I_MAX,
  parameter int J_MAX  = PIX_J_MAX,
  parameter int STARVE = PIX_STARVE
) (
  input  logic                clk,
  input  logic                rst,
  pixel_mem_arbiter_if.slave  cpu,
  input  logic                disp_req,
  input  logic                disp_frame_start,
  output logic                disp_valid,
  output logic [1:0]          disp_data,
  output logic [N/2-1:0]      disp_x,
  output logic [N/2-1:0]      disp_y,
  output logic                mem_enable,
  output logic [N-1:0]        mem_address,
  output logic [N-1:0]        mem_data_in,
  input  logic [N-1:0]        mem_data_out
);

  localparam int H  = N / 2;
  localparam int SW = (STARVE > 1) ? $clog2(STARVE) : 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE - 1);

  pix_state_e  state_q, state_d;

  // A CPU access whose ack is due next cycle: an in-range read, or any
  // out-of-range access. While set, the CPU is not granted again.
  logic        pend_q, pend_d;
  logic        pend_err_q, pend_err_d;
  logic        pend_rd_q, pend_rd_d;

  logic [SW-1:0] starve_q, starve_d;

  logic        cpu_ack_q, cpu_ack_d;
  logic        cpu_err_q, cpu_err_d;
  // High during the ack cycle of an in-range read: rdata comes straight
  // from the memory output register that cycle, and is latched after it.
  logic        rd_live_q, rd_live_d;
  logic [1:0]  rdata_q, rdata_d;

  logic        disp_valid_q, disp_valid_d;
  logic [H-1:0] disp_x_q, disp_x_d;
  logic [H-1:0] disp_y_q, disp_y_d;

  logic        mem_enable_q, mem_enable_d;
  logic [N-1:0] mem_address_q, mem_address_d;
  logic [N-1:0] mem_data_in_q, mem_data_in_d;

  logic [H-1:0] scan_x_s, scan_y_s;
  logic         scan_advance_s;
  logic         cpu_ok_s;
  logic         cpu_in_range_s;
  logic         unused_bits_s;

  assign cpu_ok_s       = cpu.cpu_req && !pend_q;
  assign cpu_in_range_s = pix_in_range(cpu.cpu_addr, PIX_HALF'(I_MAX), PIX_HALF'(J_MAX));
  assign unused_bits_s  = ^{mem_data_out[N-1:2], cpu.cpu_wdata[N-1:2]};

  pixel_scan_counter #(
    .X_MAX (I_MAX),
    .Y_MAX (J_MAX),
    .W     (H)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .advance (scan_advance_s),
    .restart (disp_frame_start),
    .x       (scan_x_s),
    .y       (scan_y_s)
  );

  // Arbitration, grant outputs and the ack/display return pipeline.
  always_comb begin
    state_d        = S_IDLE;
    pend_d         = 1'b0;
    pend_err_d     = 1'b0;
    pend_rd_d      = 1'b0;
    starve_d       = {SW{1'b0}};
    cpu_ack_d      = pend_q;
    cpu_err_d      = pend_q && pend_err_q;
    rd_live_d      = pend_q && pend_rd_q && !pend_err_q;
    mem_enable_d   = 1'b0;
    mem_address_d  = {N{1'b0}};
    mem_data_in_d  = {N{1'b0}};
    scan_advance_s = 1'b0;

    // Return stage: whatever was read last cycle is now on mem_data_out.
    disp_valid_d = (state_q == S_DISP);
    if (disp_valid_d) begin
      disp_x_d = mem_address_q[H-1:0];
      disp_y_d = mem_address_q[N-1:H];
    end else begin
      disp_x_d = {H{1'b0}};
      disp_y_d = {H{1'b0}};
    end

    if (rd_live_q) begin
      rdata_d = mem_data_out[1:0];
    end else if (pend_q && pend_rd_q && pend_err_q) begin
      rdata_d = 2'b00;
    end else begin
      rdata_d = rdata_q;
    end

    if (cpu_ok_s && !cpu_in_range_s) begin
      // Rejected access needs no memory slot, so the display still runs.
      pend_d     = 1'b1;
      pend_err_d = 1'b1;
      pend_rd_d  = !cpu.cpu_we;
      if (disp_req) begin
        state_d = S_DISP;
      end else begin
        state_d = S_IDLE;
      end
    end else if (cpu_ok_s && (!disp_req || (starve_q == STARVE_LAST))) begin
      mem_address_d = cpu.cpu_addr;
      if (cpu.cpu_we) begin
        state_d       = S_CPU_WR;
        mem_enable_d  = 1'b1;
        mem_data_in_d = {{(N-2){1'b0}}, cpu.cpu_wdata[1:0]};
        cpu_ack_d     = 1'b1;
      end else begin
        state_d   = S_CPU_RD;
        pend_d    = 1'b1;
        pend_rd_d = 1'b1;
      end
    end else if (disp_req) begin
      state_d = S_DISP;
      // Count only cycles where a grantable CPU request lost to the display.
      if (cpu_ok_s) begin
        starve_d = starve_q + 1'b1;
      end else begin
        starve_d = {SW{1'b0}};
      end
    end else begin
      state_d = S_IDLE;
    end

    // Display grant issues the current scan position and steps the counter.
    if (state_d == S_DISP) begin
      mem_address_d  = {scan_y_s, scan_x_s};
      scan_advance_s = 1'b1;
    end else begin
      scan_advance_s = 1'b0;
    end
  end

  // State and output registers; reset drops any in-flight ack, valid or write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pend_q        <= 1'b0;
      pend_err_q    <= 1'b0;
      pend_rd_q     <= 1'b0;
      starve_q      <= {SW{1'b0}};
      cpu_ack_q     <= 1'b0;
      cpu_err_q     <= 1'b0;
      rd_live_q     <= 1'b0;
      rdata_q       <= 2'b00;
      disp_valid_q  <= 1'b0;
      disp_x_q      <= {H{1'b0}};
      disp_y_q      <= {H{1'b0}};
      mem_enable_q  <= 1'b0;
      mem_address_q <= {N{1'b0}};
      mem_data_in_q <= {N{1'b0}};
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_err_q    <= pend_err_d;
      pend_rd_q     <= pend_rd_d;
      starve_q      <= starve_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_err_q     <= cpu_err_d;
      rd_live_q     <= rd_live_d;
      rdata_q       <= rdata_d;
      disp_valid_q  <= disp_valid_d;
      disp_x_q      <= disp_x_d;
      disp_y_q      <= disp_y_d;
      mem_enable_q  <= mem_enable_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign cpu.cpu_ack   = cpu_ack_q;
  assign cpu.cpu_err   = cpu_err_q;
  assign cpu.cpu_rdata = rd_live_q ? {{(N-2){1'b0}}, mem_data_out[1:0]}
                                   : {{(N-2){1'b0}}, rdata_q};
  assign disp_valid    = disp_valid_q;
  assign disp_data     = disp_valid_q ? mem_data_out[1:0] : 2'b00;
  assign disp_x        = disp_x_q;
  assign disp_y        = disp_y_q;
  assign mem_enable    = mem_enable_q;
  assign mem_address   = mem_address_q;
  assign mem_data_in   = mem_data_in_q;

endmodule

// File: doc/pixel_mem_arbiter.md
Name: pixel_mem_arbiter

Overview:
- Shares the single-port 2-bit-per-address pixel memory between two requesters: the CPU load/store path (random access) and the display scan-out path (sequential raster reads).
- Owns the memory's enable/address/data_in and consumes its registered data_out.
- Display has priority; a starvation counter guarantees CPU progress.
- Sits between the core's memory-mapped pixel region decode and the pixel memory instance.

Parameters:
- N, 32, address/data width; address = {row j [N-1:N/2], pair index i [N/2-1:0]}
- I_MAX, 320, pixel pairs per row (640 pixels / 2)
- J_MAX, 240, rows per frame
- STARVE, 8, consecutive cycles a pending CPU request may lose before it is forced through

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU request; held with stable addr/we/wdata until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  N  {j, i}
- cpu_wdata  in  N  bits [1:0] written, rest ignored
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  pulses with cpu_ack when address is out of range
- cpu_rdata  out  N  {N-2 zeros, pixel pair}; held until next CPU read completes
- disp_req  in  1  level: display wants the next pixel pair
- disp_frame_start  in  1  pulse: restart scan at (0,0)
- disp_valid  out  1  pixel pair valid this cycle
- disp_data  out  2  pixel pair
- disp_x  out  N/2  pair index of the data being returned
- disp_y  out  N/2  row of the data being returned
- mem_enable  out  1  memory write enable (memory writes on negedge while high)
- mem_address  out  N  memory address
- mem_data_in  out  N  memory write data
- mem_data_out  in  N  memory read data, registered at posedge when enable low

Behaviour:
- Reset: all outputs 0, FSM = S_IDLE, scan counters (0,0), starve count 0, no read outstanding.
- One grant per cycle. Grant outputs (mem_enable, mem_address, mem_data_in) are registered.
  - A grant decided at edge e drives memory during cycle e..e+1.
  - A write commits at the negedge inside that cycle.
  - A read is captured by memory at edge e+1.
- FSM states: S_IDLE, S_DISP, S_CPU_WR, S_CPU_RD. Next state is evaluated every edge:
  - If cpu_req, no CPU read outstanding, and (!disp_req or starve_cnt == STARVE-1): go to S_CPU_WR/S_CPU_RD per cpu_we.
  - Else if disp_req: S_DISP.
  - Else: S_IDLE.
- mem_enable is high only in S_CPU_WR; it is 0 in all other states, so memory reads are never blocked.
- S_DISP:
  - mem_address = {scan_y, scan_x}.
  - scan_x increments; at I_MAX-1 it wraps to 0 and scan_y increments; scan_y wraps J_MAX-1 -> 0.
  - One cycle after the grant (after edge e+1): disp_valid = 1, disp_data = mem_data_out[1:0], disp_x/disp_y = the issued coordinates (registered pipeline copy).
- S_CPU_WR: cpu_ack pulses in the grant cycle. The requester may change inputs in the following cycle.
- S_CPU_RD: cpu_ack pulses one cycle after the grant, with cpu_rdata updated from mem_data_out[1:0]. The CPU is not regranted while this read is outstanding.
- Range check: if i >= I_MAX or j >= J_MAX, no memory access is issued (mem_enable stays 0). cpu_ack and cpu_err pulse next cycle; cpu_rdata = 0 for a read. This takes no memory slot, so the display may be granted in parallel.
- Starvation counter:
  - Increments each cycle cpu_req is pending and display wins.
  - Clears on any CPU grant or when cpu_req is low.
  - Saturates at STARVE-1.
- disp_frame_start: scan resets to (0,0) at the next edge. It overrides increment if simultaneous with an S_DISP grant; that grant still uses the old coordinates, and the next read uses (0,0).
- rst mid-operation: any outstanding ack or valid is dropped, with no spurious pulse after reset. A write in flight during the reset cycle is abandoned (mem_enable forced 0 at that edge).

Decomposition:
- Shared package pixel_pkg:
  - state enum (S_IDLE, S_DISP, S_CPU_WR, S_CPU_RD)
  - constants I_MAX=320, J_MAX=240
  - address field helpers: row/pair extraction, range-check function
- Sub-module pixel_scan_counter: x/y raster counter with advance, restart and wrap. It is reused by the VGA timing block.

Test Plan:
- Reset, then CPU write (addr {j=5,i=10}, wdata=2'b10), then CPU read same addr -> write ack in grant cycle; mem_enable high exactly one cycle; read ack next-after-grant with cpu_rdata=0x2.
- disp_req held 400 cycles after frame_start -> disp_valid every cycle; coordinates (0,0),(1,0)..(319,0),(0,1); data matches preloaded pattern.
- disp_req continuously high plus cpu_req write -> CPU granted on the 8th contested cycle (starve_cnt hits 7); exactly one display slot lost.
- CPU read to i=320 (out of range) -> cpu_ack and cpu_err pulse one cycle later; rdata=0; mem_enable never asserted.
- Scan at (319,239) -> next read (0,0); disp_frame_start coincident with a grant -> that read uses old coords, next uses (0,0).
- rst asserted the cycle after a CPU read grant -> no cpu_ack, all outputs 0 next cycle, FSM S_IDLE.
